fm_envgen: RTL and testbench



---
 rtl/fm_envgen.sv | 125 ++++++++++++
 tb/tb_fm_envgen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fm_envgen.sv
// fm_envgen: single-operator ADSR envelope plus total-level offset giving a 12-bit attenuation word.
// Latency: env/state update on the sample_tick cycle; atten registered one clk behind env. No backpressure.
// Optional tremolo term and am_en port with FM_ENVGEN_TREMOLO_EN.
module fm_envgen (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_tick,
   input  logic        key_on,
   input  logic [3:0]  attack_rate,
   input  logic [3:0]  decay_rate,
   input  logic [3:0]  sustain_level,
   input  logic [3:0]  release_rate,
   input  logic [5:0]  total_level,
`ifdef FM_ENVGEN_TREMOLO_EN
   input  logic        am_en,
`endif
   output logic [11:0] atten,
   output logic [2:0]  env_state
);

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  env_q, env_d;
   logic        prev_key_q, prev_key_d;
   logic [14:0] tick_cnt_q, tick_cnt_d;
   logic [11:0] atten_q, atten_d;

   logic        step_a, step_d, step_r;
   logic [8:0]  attack_dec;
   logic [4:0]  trem_term;
   logic [13:0] atten_sum;

   // Rate R steps when the low (15-R) bits of the pre-increment count are all zero.
   function automatic logic rate_step(input logic [3:0] rate, input logic [14:0] cnt);
      logic [14:0] mask;
      mask = 15'h7FFF >> rate;
      return (rate != 4'd0) && ((cnt & mask) == 15'd0);
   endfunction

   always_comb begin
      step_a     = rate_step(attack_rate, tick_cnt_q);
      step_d     = rate_step(decay_rate, tick_cnt_q);
      step_r     = rate_step(release_rate, tick_cnt_q);
      attack_dec = {3'b000, env_q[8:3]} + 9'd1;

      env_d      = env_q;
      state_d    = state_q;
      prev_key_d = prev_key_q;
      tick_cnt_d = tick_cnt_q;

      if (sample_tick) begin
         tick_cnt_d = tick_cnt_q + 15'd1;
         prev_key_d = key_on;
         if (key_on && !prev_key_q) begin
            if (attack_rate == 4'd15) begin
               env_d   = 9'd0;
               state_d = ST_DECAY;
            end else begin
               state_d = ST_ATTACK;
            end
         end else if (!key_on && prev_key_q && (state_q != ST_OFF)) begin
            state_d = ST_RELEASE;
         end else begin
            case (state_q)
               ST_OFF: env_d = 9'd511;
               ST_ATTACK: begin
                  if (step_a) begin
                     env_d = (attack_dec >= env_q) ? 9'd0 : (env_q - attack_dec);
                     if (env_d == 9'd0) state_d = ST_DECAY;
                  end
               end
               ST_DECAY: begin
                  if (env_q >= {sustain_level, 5'b00000}) state_d = ST_SUSTAIN;
                  else if (step_d)                        env_d   = env_q + 9'd1;
               end
               ST_SUSTAIN: ;
               ST_RELEASE: begin
                  if (step_r) begin
                     env_d = (env_q == 9'd511) ? 9'd511 : (env_q + 9'd1);
                     if (env_d == 9'd511) state_d = ST_OFF;
                  end
               end
               default: state_d = ST_OFF;
            endcase
         end
      end
   end

   // Triangle tremolo folded from the top bits of the tick counter.
   always_comb begin
      trem_term = 5'd0;
`ifdef FM_ENVGEN_TREMOLO_EN
      if (am_en) trem_term = tick_cnt_q[14] ? ~tick_cnt_q[13:9] : tick_cnt_q[13:9];
`endif
      atten_sum = {2'b00, env_q, 3'b000} + {3'b000, total_level, 5'b00000} + {6'b000000, trem_term, 3'b000};
      atten_d   = (atten_sum > 14'd4095) ? 12'hFFF : atten_sum[11:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         env_q      <= 9'd511;
         state_q    <= ST_OFF;
         prev_key_q <= 1'b0;
         tick_cnt_q <= 15'd0;
         atten_q    <= 12'hFFF;
      end else begin
         env_q      <= env_d;
         state_q    <= state_d;
         prev_key_q <= prev_key_d;
         tick_cnt_q <= tick_cnt_d;
         atten_q    <= atten_d;
      end
   end

   assign atten     = atten_q;
   assign env_state = state_q;

endmodule

// File: tb/tb_fm_envgen.sv
// Directed bench for fm_envgen: vector table for the first phases, hand sequences for long ramps.
module tb_fm_envgen;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_tick;
   logic        key_on;
   logic [3:0]  attack_rate, decay_rate, sustain_level, release_rate;
   logic [5:0]  total_level;
`ifdef FM_ENVGEN_TREMOLO_EN
   logic        am_en;
`endif
   logic [11:0] atten;
   logic [2:0]  env_state;

   int tests = 0;
   int fails = 0;
   int tc    = 0;

   fm_envgen dut (
      .clk           (clk),
      .reset         (reset),
      .sample_tick   (sample_tick),
      .key_on        (key_on),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .sustain_level (sustain_level),
      .release_rate  (release_rate),
      .total_level   (total_level),
`ifdef FM_ENVGEN_TREMOLO_EN
      .am_en         (am_en),
`endif
      .atten         (atten),
      .env_state     (env_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        key;
      logic [3:0]  ar, dr, sl, rr;
      logic [5:0]  tl;
      logic        do_tick;
      logic [2:0]  exp_state;
      logic [11:0] exp_atten;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_both(input string name, input int exp_state, input int exp_atten);
      check({name, ".state"}, int'(env_state), exp_state);
      check({name, ".atten"}, int'(atten), exp_atten);
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   // One tick, then one extra cycle so the registered atten has caught up.
   task automatic tick();
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      tc++;
      @(negedge clk);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int st;
      int pre;
      int dec;
      bit done;

      vecs[0] = '{1'b0, 4'd0,  4'd0,  4'd0, 4'd0,  6'd0,  1'b1, 3'd0, 12'd4088};
      vecs[1] = '{1'b0, 4'd0,  4'd0,  4'd0, 4'd0,  6'd63, 1'b0, 3'd0, 12'd4095};
      vecs[2] = '{1'b0, 4'd0,  4'd0,  4'd0, 4'd0,  6'd0,  1'b0, 3'd0, 12'd4088};
      vecs[3] = '{1'b1, 4'd15, 4'd15, 4'd4, 4'd15, 6'd0,  1'b1, 3'd2, 12'd0};
      vecs[4] = '{1'b1, 4'd15, 4'd15, 4'd4, 4'd15, 6'd0,  1'b1, 3'd2, 12'd8};
      vecs[5] = '{1'b1, 4'd15, 4'd15, 4'd4, 4'd15, 6'd2,  1'b0, 3'd2, 12'd72};
      vecs[6] = '{1'b1, 4'd15, 4'd15, 4'd4, 4'd15, 6'd0,  1'b1, 3'd2, 12'd16};

      reset = 1'b1; sample_tick = 1'b0; key_on = 1'b0;
      attack_rate = 4'd0; decay_rate = 4'd0; sustain_level = 4'd0; release_rate = 4'd0;
      total_level = 6'd0;
`ifdef FM_ENVGEN_TREMOLO_EN
      am_en = 1'b0;
`endif
      idle(); idle();
      check_both("reset", 0, 4095);
      reset = 1'b0;
      idle();
      check_both("post_reset", 0, 4088);

      for (int i = 0; i < 7; i++) begin
         key_on        = vecs[i].key;
         attack_rate   = vecs[i].ar;
         decay_rate    = vecs[i].dr;
         sustain_level = vecs[i].sl;
         release_rate  = vecs[i].rr;
         total_level   = vecs[i].tl;
         if (vecs[i].do_tick) tick();
         else                 idle();
         check_both($sformatf("vec%0d", i), int'(vecs[i].exp_state), int'(vecs[i].exp_atten));
      end

      // Decay ramp to sustain level 4*32 = 128.
      repeat (126) tick();
      check_both("decay_128", 2, 1024);
      tick();
      check_both("enter_sustain", 3, 1024);
      tick();
      check_both("sustain_hold", 3, 1024);
      total_level = 6'd1;
      idle();
      check_both("sustain_tl1", 3, 1056);
      total_level = 6'd0;
      idle();

      key_on = 1'b0;
      tick();
      check_both("enter_release", 4, 1024);
      repeat (382) tick();
      check_both("release_510", 4, 4080);
      tick();
      check_both("release_off", 0, 4088);
      tick();
      check_both("off_hold", 0, 4088);

      key_on = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle();
         check_both($sformatf("pulse%0d", i), 0, 4088);
      end
      key_on = 1'b0;
      tick();
      check_both("pulse_ignored", 0, 4088);
      total_level = 6'd63;
      idle();
      check_both("tl63_sat", 0, 4095);
      total_level = 6'd0;
      idle();

      // Attack at rate 14 steps on even pre-increment counts.
      attack_rate = 4'd14; decay_rate = 4'd0; sustain_level = 4'd4;
      key_on = 1'b1;
      tick();
      check_both("ar14_enter", 1, 4088);
      e = 511; st = 1; done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         pre = tc;
         if ((pre % 2) == 0) begin
            dec = (e >> 3) + 1;
            e   = (dec >= e) ? 0 : e - dec;
            if (e == 0) st = 2;
         end
         tick();
         check_both($sformatf("ar14_t%0d", i), st, e * 8);
         if (st == 2) done = 1'b1;
      end
      check("ar14_reached_decay", int'(done), 1);

      // Reset on a tick cycle during Attack.
      reset = 1'b1; key_on = 1'b0;
      idle();
      reset = 1'b0; tc = 0;
      attack_rate = 4'd1; key_on = 1'b1;
      tick();
      check_both("attack_r1", 1, 4088);
      reset = 1'b1; sample_tick = 1'b1;
      idle();
      check_both("reset_on_tick", 0, 4095);
      sample_tick = 1'b0; key_on = 1'b0;
      idle();
      reset = 1'b0; tc = 0;
      idle();

`ifdef FM_ENVGEN_TREMOLO_EN
      attack_rate = 4'd15; sustain_level = 4'd0; key_on = 1'b1;
      tick();
      check_both("trem_decay", 2, 0);
      tick();
      check_both("trem_sustain", 3, 0);
      sample_tick = 1'b1;
      repeat (16'h3E00 - tc) @(negedge clk);
      sample_tick = 1'b0;
      tc = 16'h3E00;
      idle();
      am_en = 1'b1;
      idle();
      check_both("trem_on", 3, 248);
      am_en = 1'b0;
      idle();
      check_both("trem_off", 3, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
